// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - icache miss-refill engine: four serial byte reads assembled into a little-endian fill word
// Optional combinational early-forward outputs bypassValid/bypassInst exist only when ICACHE_REFILL_BYPASS_EN is defined.
module icache_refill #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              fetchEn,
    input  logic [ADDR_W-1:0] fetchAddr,
    input  logic              flush,
    input  logic [7:0]        mem_din,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_re,
    output logic              addEn,
    output logic [31:0]       addInst,
    output logic [ADDR_W-1:0] addAddr,
`ifdef ICACHE_REFILL_BYPASS_EN
    output logic              busy,
    output logic              bypassValid,
    output logic [31:0]       bypassInst
`else
    output logic              busy
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        FILL = 2'd2
    } state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] base;
    logic [7:0]        b0;
    logic [7:0]        b1;
    logic [7:0]        b2;

    assign busy = (state != IDLE);

`ifdef ICACHE_REFILL_BYPASS_EN
    // Last byte is forwarded straight from the RAM port, one cycle ahead of addEn.
    assign bypassValid = (state == READ) && (cnt == 3'd4) && rdy && !flush && rst;
    assign bypassInst  = {mem_din, b2, b1, b0};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            base    <= '0;
            b0      <= 8'h00;
            b1      <= 8'h00;
            b2      <= 8'h00;
            mem_a   <= '0;
            mem_re  <= 1'b0;
            addEn   <= 1'b0;
            addInst <= 32'h0;
            addAddr <= '0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    mem_re <= 1'b0;
                    if (fetchEn && !flush) begin
                        base   <= fetchAddr;
                        mem_a  <= fetchAddr;
                        mem_re <= 1'b1;
                        cnt    <= 3'd0;
                        state  <= READ;
                    end
                end
                READ: begin
                    if (flush) begin
                        mem_re <= 1'b0;
                        cnt    <= 3'd0;
                        state  <= IDLE;
                    end else if (cnt == 3'd4) begin
                        addInst <= {mem_din, b2, b1, b0};
                        addAddr <= base;
                        addEn   <= 1'b1;
                        cnt     <= 3'd0;
                        state   <= FILL;
                    end else begin
                        // mem_din always carries the byte for the address issued one cycle earlier
                        case (cnt)
                            3'd1:    b0 <= mem_din;
                            3'd2:    b1 <= mem_din;
                            3'd3:    b2 <= mem_din;
                            default: ;
                        endcase
                        if (cnt < 3'd3) begin
                            mem_a <= base + ADDR_W'(cnt) + ADDR_W'(1);
                        end else begin
                            mem_re <= 1'b0;
                        end
                        cnt <= cnt + 3'd1;
                    end
                end
                FILL: begin
                    // fetchEn is still the stale miss here; ignoring it avoids a duplicate refill
                    addEn <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - directed bench for icache_refill with a byte-wide registered RAM model
module tb_icache_refill;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        fetchEn;
    logic [31:0] fetchAddr;
    logic        flush;
    logic [7:0]  mem_din;
    logic [31:0] mem_a;
    logic        mem_re;
    logic        addEn;
    logic [31:0] addInst;
    logic [31:0] addAddr;
    logic        busy;
`ifdef ICACHE_REFILL_BYPASS_EN
    logic        bypassValid;
    logic [31:0] bypassInst;
`endif

    int checks = 0;
    int errors = 0;

    icache_refill #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .fetchEn    (fetchEn),
        .fetchAddr  (fetchAddr),
        .flush      (flush),
        .mem_din    (mem_din),
        .mem_a      (mem_a),
        .mem_re     (mem_re),
        .addEn      (addEn),
        .addInst    (addInst),
        .addAddr    (addAddr),
`ifdef ICACHE_REFILL_BYPASS_EN
        .busy       (busy),
        .bypassValid(bypassValid),
        .bypassInst (bypassInst)
`else
        .busy       (busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents: fixed instruction at 0x1000, elsewhere low address byte + 0x21
    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        case (a)
            32'h0000_1000: ram_byte = 8'h13;
            32'h0000_1001: ram_byte = 8'h05;
            32'h0000_1002: ram_byte = 8'h10;
            32'h0000_1003: ram_byte = 8'h00;
            default:       ram_byte = a[7:0] + 8'h21;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rdy) mem_din <= ram_byte(mem_a);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mem_a"},   64'(mem_a),   64'h0);
        check({tag, "_mem_re"},  64'(mem_re),  64'h0);
        check({tag, "_addEn"},   64'(addEn),   64'h0);
        check({tag, "_addInst"}, 64'(addInst), 64'h0);
        check({tag, "_addAddr"}, 64'(addAddr), 64'h0);
        check({tag, "_busy"},    64'(busy),    64'h0);
`ifdef ICACHE_REFILL_BYPASS_EN
        check({tag, "_bypassValid"}, 64'(bypassValid), 64'h0);
`endif
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; fetchEn = 1'b0; fetchAddr = 32'h0; flush = 1'b0; mem_din = 8'h00;
        tick(); tick();
        check_reset_vals("reset");
        rst = 1'b1;
        tick();

        // Basic refill of 0x1000, fetchEn held through FILL with a changed address
        fetchEn = 1'b1; fetchAddr = 32'h0000_1000;
        tick();
        check("e0_mem_a",  64'(mem_a),  64'h1000);
        check("e0_mem_re", 64'(mem_re), 64'h1);
        check("e0_busy",   64'(busy),   64'h1);
        fetchAddr = 32'h0000_5555;
        tick();
        check("e1_mem_a", 64'(mem_a), 64'h1001);
        tick();
        check("e2_mem_a", 64'(mem_a), 64'h1002);
        tick();
        check("e3_mem_a",  64'(mem_a),  64'h1003);
        check("e3_mem_re", 64'(mem_re), 64'h1);
        check("e3_addEn",  64'(addEn),  64'h0);
        tick();
        check("e4_mem_re", 64'(mem_re), 64'h0);
        check("e4_addEn",  64'(addEn),  64'h0);
`ifdef ICACHE_REFILL_BYPASS_EN
        check("e4_bypassValid", 64'(bypassValid), 64'h1);
        check("e4_bypassInst",  64'(bypassInst),  64'h0010_0513);
`endif
        tick();
        check("e5_addEn",   64'(addEn),   64'h1);
        check("e5_addInst", 64'(addInst), 64'h0010_0513);
        check("e5_addAddr", 64'(addAddr), 64'h1000);
        tick();
        check("e6_addEn", 64'(addEn), 64'h0);
        check("e6_busy",  64'(busy),  64'h0);
        tick();
        check("e7_accept_busy",  64'(busy),  64'h1);
        check("e7_accept_mem_a", 64'(mem_a), 64'h5555);
        fetchEn = 1'b0;
        repeat (5) tick();
        check("r2_addEn",   64'(addEn),   64'h1);
        check("r2_addInst", 64'(addInst), 64'h7978_7776);
        check("r2_addAddr", 64'(addAddr), 64'h5555);
        tick();
        check("r2_fill_done", 64'(addEn), 64'h0);
        tick();
        check("r2_idle", 64'(busy), 64'h0);

        // Flush at cnt==2 of 0x2000, then 0x3000 completes
        fetchEn = 1'b1; fetchAddr = 32'h0000_2000;
        tick();
        fetchEn = 1'b0;
        tick(); tick();
        flush = 1'b1;
        tick();
        check("flush_busy",   64'(busy),   64'h0);
        check("flush_mem_re", 64'(mem_re), 64'h0);
        check("flush_addEn",  64'(addEn),  64'h0);
        flush = 1'b0; fetchEn = 1'b1; fetchAddr = 32'h0000_3000;
        tick();
        check("post_flush_mem_a", 64'(mem_a), 64'h3000);
        check("post_flush_busy",  64'(busy),  64'h1);
        fetchEn = 1'b0;
        repeat (4) tick();
        check("post_flush_e4_addEn", 64'(addEn), 64'h0);
        tick();
        check("post_flush_addEn",   64'(addEn),   64'h1);
        check("post_flush_addInst", 64'(addInst), 64'h2423_2221);
        check("post_flush_addAddr", 64'(addAddr), 64'h3000);
        tick(); tick();

        // rdy low for three cycles at cnt==1
        fetchEn = 1'b1; fetchAddr = 32'h0000_4010;
        tick();
        fetchEn = 1'b0;
        tick();
        rdy = 1'b0;
        repeat (3) tick();
        check("stall_mem_a", 64'(mem_a), 64'h4011);
        check("stall_busy",  64'(busy),  64'h1);
        rdy = 1'b1;
        repeat (3) tick();
        check("stall_e7_addEn", 64'(addEn), 64'h0);
        tick();
        check("stall_addEn",   64'(addEn),   64'h1);
        check("stall_addInst", 64'(addInst), 64'h3433_3231);
        check("stall_addAddr", 64'(addAddr), 64'h4010);
        tick(); tick();

        // Address wrap
        fetchEn = 1'b1; fetchAddr = 32'hFFFF_FFFE;
        tick();
        fetchEn = 1'b0;
        check("wrap_a0", 64'(mem_a), 64'hFFFF_FFFE);
        tick();
        check("wrap_a1", 64'(mem_a), 64'hFFFF_FFFF);
        tick();
        check("wrap_a2", 64'(mem_a), 64'h0000_0000);
        tick();
        check("wrap_a3", 64'(mem_a), 64'h0000_0001);
        tick(); tick();
        check("wrap_addEn",   64'(addEn),   64'h1);
        check("wrap_addInst", 64'(addInst), 64'h2221_201F);
        check("wrap_addAddr", 64'(addAddr), 64'hFFFF_FFFE);
        tick(); tick();

        // Reset mid-refill at cnt==3
        fetchEn = 1'b1; fetchAddr = 32'h0000_1000;
        tick();
        fetchEn = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        check_reset_vals("midrst");
        rst = 1'b1;
        repeat (3) tick();
        check("midrst_no_fill", 64'(addEn), 64'h0);
        check("midrst_idle",    64'(busy),  64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_refill.md
# icache_refill

Miss-refill engine on the memory side of the instruction cache. Accepts a miss request (fetch enable plus address) from the icache, reads the four instruction bytes serially over the byte-wide RAM read port, assembles a little-endian 32-bit word and returns it to the icache as a one-cycle fill (add enable, instruction, address). Sits between the icache and the RAM/arbiter port.

## Interface
- ADDR_W, 32, address width (fetch, fill and RAM addresses).
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-low.
- rdy  in  1  global ready; low = freeze all state and outputs.
- fetchEn  in  1  miss request from icache (memfetchEn).
- fetchAddr  in  ADDR_W  miss address (memfetchAddr).
- flush  in  1  pipeline flush; aborts an in-flight refill.
- mem_din  in  8  RAM read data; byte for address presented one cycle earlier.
- mem_a  out  ADDR_W  RAM byte address (registered).
- mem_re  out  1  RAM read strobe (registered).
- addEn  out  1  fill pulse to icache (registered).
- addInst  out  32  filled instruction word.
- addAddr  out  ADDR_W  address of filled word.
- busy  out  1  high whenever state != IDLE.
- bypassValid  out  1  only with ICACHE_REFILL_BYPASS_EN.
- bypassInst  out  32  only with ICACHE_REFILL_BYPASS_EN.

## Operation
- States: IDLE, READ (3-bit byte counter cnt 0..4), FILL.
- IDLE: fetchEn=1 and flush=0 at edge -> latch base=fetchAddr, mem_a<=base, mem_re<=1, cnt<=0, -> READ. Otherwise stay; mem_re=0.
- READ, each edge: if cnt>=1 capture mem_din into byte[cnt-1]; if cnt<3 mem_a<=base+cnt+1, else mem_re<=0; cnt<=cnt+1. At cnt==4 edge: capture byte3, addInst<={b3,b2,b1,b0}, addAddr<=base, addEn<=1, -> FILL.
- FILL: addEn high exactly this cycle; next edge addEn<=0, -> IDLE. fetchEn ignored in FILL (icache writes on this edge; stale miss must not retrigger).
- Address arithmetic modulo 2^ADDR_W; base not realigned; 0xFFFFFFFE reads FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- flush=1 in READ: -> IDLE, mem_re<=0, no fill, captured bytes discarded. flush in IDLE beats fetchEn. flush in FILL: fill completes (data valid).
- fetchAddr changes during READ are ignored (base latched).
- rdy=0: no state, counter, register or output change; RAM side also gated by rdy, so mem_din is held.
- Priority per edge: rst low > rdy low > flush > normal.

## Timing
- Reset values: mem_a=0, mem_re=0, addEn=0, addInst=0, addAddr=0, busy=0, state IDLE, bypassValid=0.
- Accept edge E0 -> mem_a=base..base+3 during cycles E0..E3; mem_re high cycles E0-E3.
- addEn high in cycle following E5 (5 edges after accept, rdy high throughout); FILL->IDLE at E6; earliest next accept E7.
- Each rdy-low cycle adds exactly one cycle of latency.
- Reset mid-refill: returns to reset values at that edge, no fill issued.

## Configuration
- ICACHE_REFILL_BYPASS_EN defined: bypassValid = (state==READ) & (cnt==4) & rdy & ~flush & rst; bypassInst = {mem_din, b2, b1, b0}, combinational, one cycle before addEn, same word, for direct forwarding to fetch.
- Undefined: bypassValid/bypassInst ports absent; all other behaviour identical.

## Test plan
- Reset then fetchEn=1, fetchAddr=0x1000, RAM bytes 0x13,0x05,0x10,0x00 -> mem_a 0x1000..0x1003 on cycles 0-3, single addEn pulse 5 edges after accept, addInst=0x00100513, addAddr=0x1000.
- fetchEn held high through FILL -> exactly one refill; next accepted only after FILL->IDLE.
- flush at cnt==2 during refill of 0x2000 -> no addEn, busy low next cycle; new request 0x3000 next cycle completes normally.
- rdy low 3 cycles at cnt==1 -> fill delayed exactly 3 cycles, word unchanged.
- fetchAddr=0xFFFFFFFE -> mem_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001; addAddr=0xFFFFFFFE.
- rst low at cnt==3 -> all outputs reset values that edge, no addEn; with macro defined, bypassValid one cycle before addEn with bypassInst==addInst.
